// File: rtl/rv32_bus_arbiter_if.sv
// Shared memory-bus bundle between N requesting masters and one slave.
// The arbiter uses the master modport; the surrounding system uses slave.
interface rv32_bus_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic [NUM_PORTS*ADDR_WIDTH-1:0] m_address_in;
    logic [NUM_PORTS-1:0]            m_read_in;
    logic [NUM_PORTS-1:0]            m_write_in;
    logic [NUM_PORTS*MASK_WIDTH-1:0] m_write_mask_in;
    logic [NUM_PORTS*DATA_WIDTH-1:0] m_write_value_in;
    logic [NUM_PORTS*DATA_WIDTH-1:0] m_read_value_out;
    logic [NUM_PORTS-1:0]            m_ready_out;

    logic [ADDR_WIDTH-1:0]           s_address_out;
    logic                            s_read_out;
    logic                            s_write_out;
    logic [MASK_WIDTH-1:0]           s_write_mask_out;
    logic [DATA_WIDTH-1:0]           s_write_value_out;
    logic [DATA_WIDTH-1:0]           s_read_value_in;
    logic                            s_ready_in;

    logic [NUM_PORTS-1:0]            grant_out;

    modport master (
        input  m_address_in,
        input  m_read_in,
        input  m_write_in,
        input  m_write_mask_in,
        input  m_write_value_in,
        output m_read_value_out,
        output m_ready_out,
        output s_address_out,
        output s_read_out,
        output s_write_out,
        output s_write_mask_out,
        output s_write_value_out,
        input  s_read_value_in,
        input  s_ready_in,
        output grant_out
    );

    modport slave (
        output m_address_in,
        output m_read_in,
        output m_write_in,
        output m_write_mask_in,
        output m_write_value_in,
        input  m_read_value_out,
        input  m_ready_out,
        input  s_address_out,
        input  s_read_out,
        input  s_write_out,
        input  s_write_mask_out,
        input  s_write_value_out,
        output s_read_value_in,
        output s_ready_in,
        input  grant_out
    );
endinterface

// File: rtl/rv32_bus_arbiter.sv
// N-master to 1-slave memory bus arbiter, fixed-priority or round-robin.
// A grant stays frozen across slave wait states until done or abandoned.
module rv32_bus_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    rv32_bus_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int MW = DATA_WIDTH / 8;

    typedef logic [IW-1:0] idx_t;
    typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

    state_t state_q, state_d;
    idx_t   grant_q, grant_d;
    idx_t   last_q, last_d;

    logic [NUM_PORTS-1:0]  req;
    logic [ADDR_WIDTH-1:0] addr_a [NUM_PORTS];
    logic [MW-1:0]         mask_a [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wval_a [NUM_PORTS];

    idx_t fp_idx, rr_idx, g;
    logic fp_hit, rr_hit, active;

    logic [NUM_PORTS-1:0] gnt, rdy;

    assign req = bus.m_read_in | bus.m_write_in;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slice
        assign addr_a[i] = bus.m_address_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign mask_a[i] = bus.m_write_mask_in[i*MW +: MW];
        assign wval_a[i] = bus.m_write_value_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Lowest-index requester for fixed priority.
    always_comb begin
        fp_idx = '0;
        fp_hit = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[idx_t'(i)]) begin
                fp_idx = idx_t'(i);
                fp_hit = 1'b1;
            end
        end
    end

    // First requester after the last completed grant, wrapping around.
    always_comb begin
        int pos;
        pos    = 0;
        rr_idx = '0;
        rr_hit = 1'b0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            pos = (int'(last_q) + k) % NUM_PORTS;
            if (req[idx_t'(pos)]) begin
                rr_idx = idx_t'(pos);
                rr_hit = 1'b1;
            end
        end
    end

    // Grant choice and next-state: a live lock wins, else re-arbitrate.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        active  = 1'b0;
        g       = '0;
        if (state_q == ST_LOCKED && req[grant_q]) begin
            active = 1'b1;
            g      = grant_q;
        end else if (ROUND_ROBIN && rr_hit) begin
            active = 1'b1;
            g      = rr_idx;
        end else if (!ROUND_ROBIN && fp_hit) begin
            active = 1'b1;
            g      = fp_idx;
        end
        if (active) begin
            if (bus.s_ready_in) begin
                state_d = ST_OPEN;
                last_d  = g;
            end else begin
                state_d = ST_LOCKED;
                grant_d = g;
            end
        end else begin
            state_d = ST_OPEN;
        end
    end

    // Grant and completion vectors; only the granted bit may be set.
    always_comb begin
        gnt = '0;
        rdy = '0;
        if (active) begin
            gnt[g] = 1'b1;
            rdy[g] = bus.s_ready_in;
        end
    end

    // Lock, held grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_OPEN;
            grant_q <= '0;
            last_q  <= idx_t'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Idle forwards port 0 address/data since g defaults to zero.
    assign bus.s_address_out     = addr_a[g];
    assign bus.s_write_value_out = wval_a[g];
    assign bus.s_read_out        = active & bus.m_read_in[g];
    assign bus.s_write_out       = active & bus.m_write_in[g];
    assign bus.s_write_mask_out  = active ? mask_a[g] : '0;
    assign bus.grant_out         = gnt;
    assign bus.m_ready_out       = rdy;
    assign bus.m_read_value_out  = {NUM_PORTS{bus.s_read_value_in}};
endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Checks round-robin and fixed-priority arbiters side by side with
// directed vectors and randomized traffic against a behavioural model.
module tb_rv32_bus_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]  rd, wr;
    logic [31:0]   addr_v [N];
    logic [3:0]    mask_v [N];
    logic [31:0]   wval_v [N];
    logic          y;
    logic [31:0]   rval;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    rv32_bus_arbiter_if #(.NUM_PORTS(N)) bus_rr ();
    rv32_bus_arbiter_if #(.NUM_PORTS(N)) bus_fp ();

    assign bus_rr.m_address_in     = {addr_v[2], addr_v[1], addr_v[0]};
    assign bus_rr.m_read_in        = rd;
    assign bus_rr.m_write_in       = wr;
    assign bus_rr.m_write_mask_in  = {mask_v[2], mask_v[1], mask_v[0]};
    assign bus_rr.m_write_value_in = {wval_v[2], wval_v[1], wval_v[0]};
    assign bus_rr.s_read_value_in  = rval;
    assign bus_rr.s_ready_in       = y;

    assign bus_fp.m_address_in     = {addr_v[2], addr_v[1], addr_v[0]};
    assign bus_fp.m_read_in        = rd;
    assign bus_fp.m_write_in       = wr;
    assign bus_fp.m_write_mask_in  = {mask_v[2], mask_v[1], mask_v[0]};
    assign bus_fp.m_write_value_in = {wval_v[2], wval_v[1], wval_v[0]};
    assign bus_fp.s_read_value_in  = rval;
    assign bus_fp.s_ready_in       = y;

    rv32_bus_arbiter #(.NUM_PORTS(N), .ROUND_ROBIN(1'b1)) dut_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_rr)
    );

    rv32_bus_arbiter #(.NUM_PORTS(N), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_fp)
    );

    // A master must never read and write in the same cycle.
    always @(posedge clk) begin
        if (!reset)
            assert ((rd & wr) == '0)
            else $error("FAIL illegal rd+wr stimulus rd=%b wr=%b", rd, wr);
    end

    // Model state: holder = master owning a stalled transfer or -1;
    // last = master whose transfer completed most recently.
    int hold [2];
    int last [2];

    function automatic int model_pick(int mode);
        logic [N-1:0] req;
        int p;
        req = rd | wr;
        if (hold[mode] >= 0 && req[hold[mode]])
            return hold[mode];
        if (mode == 1) begin
            for (int i = 0; i < N; i++)
                if (req[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) begin
                p = (last[mode] + k) % N;
                if (req[p]) return p;
            end
        end
        return -1;
    endfunction

    function automatic void model_step(int mode, int g);
        if (reset) begin
            hold[mode] = -1;
            last[mode] = N - 1;
        end else if (g < 0) begin
            hold[mode] = -1;
        end else if (y) begin
            hold[mode] = -1;
            last[mode] = g;
        end else begin
            hold[mode] = g;
        end
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_dut(string tag, int g,
                             logic [N-1:0] gnt, logic [N-1:0] rdy,
                             logic srd, logic swr, logic [3:0] sm,
                             logic [31:0] sa, logic [31:0] sw,
                             logic [N*32-1:0] rv);
        logic [N-1:0] e_g;
        logic [N-1:0] e_r;
        logic [N-1:0] req;
        int s;
        req = rd | wr;
        e_g = '0;
        e_r = '0;
        if (g >= 0) begin
            e_g[g] = 1'b1;
            if (y && req[g]) e_r[g] = 1'b1;
        end
        s = (g < 0) ? 0 : g;
        check({tag, ".grant"}, gnt, e_g);
        check({tag, ".m_ready"}, rdy, e_r);
        check({tag, ".s_read"}, srd, (g >= 0) && rd[s]);
        check({tag, ".s_write"}, swr, (g >= 0) && wr[s]);
        check({tag, ".s_mask"}, sm, (g >= 0) ? mask_v[s] : 4'h0);
        check({tag, ".s_addr"}, sa, addr_v[s]);
        check({tag, ".s_wval"}, sw, wval_v[s]);
        check({tag, ".m_rval"}, rv, {N{rval}});
    endtask

    // Check one cycle, advance the model, then move past the clock edge.
    task automatic run_cycle(bit from_tbl, int t_rr, int t_fp);
        int m_rr, m_fp;
        #3;
        m_rr = model_pick(0);
        m_fp = model_pick(1);
        check_dut("rr", from_tbl ? t_rr : m_rr,
                  bus_rr.grant_out, bus_rr.m_ready_out,
                  bus_rr.s_read_out, bus_rr.s_write_out,
                  bus_rr.s_write_mask_out, bus_rr.s_address_out,
                  bus_rr.s_write_value_out, bus_rr.m_read_value_out);
        check_dut("fp", from_tbl ? t_fp : m_fp,
                  bus_fp.grant_out, bus_fp.m_ready_out,
                  bus_fp.s_read_out, bus_fp.s_write_out,
                  bus_fp.s_write_mask_out, bus_fp.s_address_out,
                  bus_fp.s_write_value_out, bus_fp.m_read_value_out);
        model_step(0, m_rr);
        model_step(1, m_fp);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] rd;
        logic [N-1:0] wr;
        logic         y;
        int           g_rr;
        int           g_fp;
    } vec_t;

    vec_t tbl [20];

    initial begin
        tbl[0]  = '{1'b0, 3'b000, 3'b000, 1'b1, -1, -1};
        tbl[1]  = '{1'b0, 3'b111, 3'b000, 1'b1,  0,  0};
        tbl[2]  = '{1'b0, 3'b111, 3'b000, 1'b1,  1,  0};
        tbl[3]  = '{1'b0, 3'b111, 3'b000, 1'b1,  2,  0};
        tbl[4]  = '{1'b0, 3'b111, 3'b000, 1'b1,  0,  0};
        tbl[5]  = '{1'b0, 3'b111, 3'b000, 1'b1,  1,  0};
        tbl[6]  = '{1'b0, 3'b111, 3'b000, 1'b1,  2,  0};
        tbl[7]  = '{1'b0, 3'b010, 3'b000, 1'b1,  1,  1};
        tbl[8]  = '{1'b0, 3'b000, 3'b010, 1'b0,  1,  1};
        tbl[9]  = '{1'b0, 3'b001, 3'b010, 1'b0,  1,  1};
        tbl[10] = '{1'b0, 3'b001, 3'b010, 1'b0,  1,  1};
        tbl[11] = '{1'b0, 3'b001, 3'b010, 1'b1,  1,  1};
        tbl[12] = '{1'b0, 3'b001, 3'b000, 1'b1,  0,  0};
        tbl[13] = '{1'b0, 3'b001, 3'b000, 1'b0,  0,  0};
        tbl[14] = '{1'b0, 3'b011, 3'b000, 1'b0,  0,  0};
        tbl[15] = '{1'b0, 3'b010, 3'b000, 1'b1,  1,  1};
        tbl[16] = '{1'b0, 3'b100, 3'b000, 1'b0,  2,  2};
        tbl[17] = '{1'b1, 3'b100, 3'b000, 1'b0,  2,  2};
        tbl[18] = '{1'b0, 3'b111, 3'b000, 1'b1,  0,  0};
        tbl[19] = '{1'b0, 3'b000, 3'b000, 1'b1, -1, -1};

        hold[0] = -1; hold[1] = -1;
        last[0] = N - 1; last[1] = N - 1;
        reset = 1'b1;
        rd = '0;
        wr = '0;
        y = 1'b0;
        rval = 32'hDEADBEEF;
        for (int i = 0; i < N; i++) begin
            addr_v[i] = 32'(i * 32'h100);
            wval_v[i] = 32'h11111111 * 32'(i + 1);
        end
        mask_v[0] = 4'hF;
        mask_v[1] = 4'h3;
        mask_v[2] = 4'hC;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            reset = tbl[i].rst;
            rd    = tbl[i].rd;
            wr    = tbl[i].wr;
            y     = tbl[i].y;
            run_cycle(1'b1, tbl[i].g_rr, tbl[i].g_fp);
        end
        reset = 1'b0;

        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < N; i++) begin
                int op;
                op = $urandom_range(0, 2);
                rd[i] = (op == 1);
                wr[i] = (op == 2);
                addr_v[i] = $urandom;
                wval_v[i] = $urandom;
                mask_v[i] = 4'($urandom_range(0, 15));
            end
            y = ($urandom_range(0, 3) != 0);
            rval = $urandom;
            run_cycle(1'b0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv32_bus_arbiter.md
Name: rv32_bus_arbiter

Overview:
- N-master to 1-slave arbiter for the core's memory bus protocol: address, read, write, write mask, write value, read value, ready.
- Lets the instruction and data buses, plus future masters such as a debug port or DMA, share one memory.
- Generalises the fixed two-bus split to NUM_PORTS channels with parametrised address and data widths.
- Selectable fixed-priority or round-robin arbitration; a grant is held until the slave completes or the master abandons.

Parameters:
NUM_PORTS, 2, number of masters (>=2); port 0 = instruction fetch by convention
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; multiple of 8
ROUND_ROBIN, 1, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m_address_in  in  NUM_PORTS*ADDR_WIDTH  per-master address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_read_in  in  NUM_PORTS  per-master read request
m_write_in  in  NUM_PORTS  per-master write request
m_write_mask_in  in  NUM_PORTS*DATA_WIDTH/8  per-master byte mask
m_write_value_in  in  NUM_PORTS*DATA_WIDTH  per-master write data
m_read_value_out  out  NUM_PORTS*DATA_WIDTH  read data, s_read_value_in broadcast to every slice
m_ready_out  out  NUM_PORTS  per-master completion; only the granted bit can be 1
s_address_out  out  ADDR_WIDTH  slave address
s_read_out  out  1  slave read
s_write_out  out  1  slave write
s_write_mask_out  out  DATA_WIDTH/8  slave byte mask
s_write_value_out  out  DATA_WIDTH  slave write data
s_read_value_in  in  DATA_WIDTH  slave read data
s_ready_in  in  1  slave completion, same cycle or later
grant_out  out  NUM_PORTS  one-hot current grant, all-zero when idle

Behaviour:
- Protocol
  - req[i] = m_read_in[i] | m_write_in[i].
  - A transaction completes in the cycle where the master's request and its m_ready_out bit are both 1.
  - Read and write together from one master is illegal; the bench asserts against it.
- State: locked (1b), grant_q (index), last_q (index of last completed grant).
- Reset values: locked=0, grant_q=0, last_q=NUM_PORTS-1, so port 0 wins the first round-robin.
- Grant selection, combinational:
  - If locked and req[grant_q], then grant = grant_q.
  - Otherwise the arbiter picks from req:
    - fixed priority: lowest set index;
    - round-robin: first set index scanning last_q+1, last_q+2, ... modulo NUM_PORTS.
  - No req set means no grant: grant_out=0, and s_read_out, s_write_out, s_write_mask_out and m_ready_out are all 0.
  - s_address_out and s_write_value_out then forward port 0's values; they are don't-care for the slave but deterministic.
- Forwarding, zero added latency:
  - The granted master's address, read, write, mask and value drive the slave.
  - m_ready_out[g] = s_ready_in & req[g]; all other m_ready_out bits are 0.
- Sequential update each cycle:
  - Grant active and s_ready_in=1: locked<=0, last_q<=g. The transaction is done and the next cycle re-arbitrates.
  - Grant active and s_ready_in=0: locked<=1, grant_q<=g. The grant is frozen and no other master can preempt, including a higher-priority one.
  - Locked master drops its request (e.g. fetch flushed on mispredict): lock ignored that cycle; a new arbitration happens combinationally in the same cycle, locked<=0 unless the new grant stalls, last_q unchanged.
- Back-to-back: a master holding its request after completion competes again next cycle.
  - Round-robin: it loses to any other requester.
  - Fixed priority: it wins again if it has the lowest index.
- Reset mid-transaction: lock cleared and all state returns to reset values on the next edge. In-flight slave transactions are the slave's responsibility; the slave is reset together with the arbiter.
- The arbiter never stores data; read data is a pure broadcast.

Test Plan:
- Single master: port 1 reads 0x100, s_ready_in=1 with read value 0xDEADBEEF -> same cycle s_read_out=1, s_address_out=0x100, m_ready_out=2'b10, slice 1 = 0xDEADBEEF, grant_out=2'b10.
- Contention under ROUND_ROBIN=1, NUM_PORTS=3: all request continuously, slave always ready -> grants 0,1,2,0,1,2; with ROUND_ROBIN=0 -> grant 0 every cycle.
- Wait-state lock: port 1 writes with mask 4'b0011, s_ready_in low 3 cycles while port 0 also requests -> grant stays port 1 for 4 cycles and s_write_mask_out stays 0011; port 0 is granted in cycle 5.
- Abandon: port 0 locked with ready low, then drops its request while port 1 requests -> port 1 granted that same cycle; port 0 gets no m_ready_out pulse.
- Reset while locked on port 2 -> next cycle locked=0, and a round-robin request from all ports grants port 0 first.
- Idle: no requests -> grant_out=0, s_read_out=s_write_out=0, m_ready_out=0 even with s_ready_in=1.
